// File: rtl/wb_unified_mem_slave_pkg.sv
// Shared definitions for the unified instruction/data memory slave:
// NOP encoding, arbiter state codes and the byte-lane merge helper.
package wb_unified_mem_slave_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      MEM_ST_IDLE  = 2'd0,
      MEM_ST_I_ACK = 2'd1,
      MEM_ST_D_ACK = 2'd2
   } mem_state_e;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/wb_unified_mem_slave_spram.sv
// DEPTH x 32 single-port RAM with per-byte write enables and a registered,
// read-before-write output port.
module wb_unified_mem_slave_spram #(
   parameter int DEPTH  = 8192,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   // Contents are intentionally never reset so a loaded image survives rst_n.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/wb_unified_mem_slave.sv
// Unified instruction+data memory behind two Wishbone masters with a
// data-first arbiter and a tohost pass/fail monitor.
//
//   state        | meaning
//   MEM_ST_IDLE  | sample dreq/ireq, launch one array access
//   MEM_ST_D_ACK | data ack/err and load data on the bus
//   MEM_ST_I_ACK | fetch ack and instruction on the bus
module wb_unified_mem_slave
   import wb_unified_mem_slave_pkg::*;
#(
   parameter int          DEPTH       = 8192,
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] iwb_adr_i,
   input  logic        iwb_cyc_i,
   input  logic        iwb_stb_i,
   output logic [31:0] iwb_dat_o,
   output logic        iwb_ack_o,
   input  logic [31:0] dwb_adr_i,
   input  logic [31:0] dwb_dat_i,
   output logic [31:0] dwb_dat_o,
   input  logic        dwb_we_i,
   input  logic [3:0]  dwb_sel_i,
   input  logic        dwb_cyc_i,
   input  logic        dwb_stb_i,
   output logic        dwb_ack_o,
   output logic        dwb_err_o,
   output logic        tohost_done_o,
   output logic        tohost_pass_o,
   output logic [30:0] tohost_code_o
);

   localparam int ADDR_W = $clog2(DEPTH);

   mem_state_e        state, state_n;
   logic              ireq, dreq;
   logic [ADDR_W-1:0] i_idx, d_idx;
   logic              i_idx_ok, d_idx_ok;
   logic              i_ok, d_ok, d_tohost;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_rdata;
   logic              i_ok_q, d_ok_q, th_hit_q;
   logic [31:0]       wdat_q;
   logic [3:0]        sel_q;
   logic [31:0]       th_word;
   logic              unused_adr;

   assign unused_adr = ^{iwb_adr_i[1:0], dwb_adr_i[1:0]};

   assign ireq  = iwb_cyc_i & iwb_stb_i;
   assign dreq  = dwb_cyc_i & dwb_stb_i;
   assign i_idx = iwb_adr_i[ADDR_W+1:2];
   assign d_idx = dwb_adr_i[ADDR_W+1:2];

   // A partially populated index space needs an explicit upper-bound check.
   if ((1 << ADDR_W) == DEPTH) begin : g_pow2
      assign i_idx_ok = 1'b1;
      assign d_idx_ok = 1'b1;
   end else begin : g_npow2
      assign i_idx_ok = (i_idx < ADDR_W'(DEPTH));
      assign d_idx_ok = (d_idx < ADDR_W'(DEPTH));
   end

   assign i_ok     = ~|iwb_adr_i[31:ADDR_W+2] & i_idx_ok;
   assign d_ok     = ~|dwb_adr_i[31:ADDR_W+2] & d_idx_ok;
   assign d_tohost = (dwb_adr_i[31:2] == TOHOST_ADDR[31:2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MEM_ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      ram_en   = 1'b0;
      ram_we   = 4'b0000;
      ram_addr = d_idx;
      case (state)
         MEM_ST_IDLE: begin
            if (dreq) begin
               state_n = MEM_ST_D_ACK;
               ram_en  = 1'b1;
               if (dwb_we_i && d_ok) ram_we = dwb_sel_i;
            end else if (ireq) begin
               state_n  = MEM_ST_I_ACK;
               ram_en   = 1'b1;
               ram_addr = i_idx;
            end
         end
         default: state_n = MEM_ST_IDLE;
      endcase
   end

   wb_unified_mem_slave_spram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (dwb_dat_i),
      .rdata (ram_rdata)
   );

   // The merged tohost value needs the old word, which only arrives in D_ACK.
   assign th_word = merge_lanes(ram_rdata, wdat_q, sel_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_ok_q        <= 1'b0;
         d_ok_q        <= 1'b0;
         th_hit_q      <= 1'b0;
         wdat_q        <= '0;
         sel_q         <= '0;
         tohost_done_o <= 1'b0;
         tohost_pass_o <= 1'b0;
         tohost_code_o <= '0;
      end else begin
         if (state == MEM_ST_IDLE && dreq) begin
            d_ok_q   <= d_ok;
            th_hit_q <= d_ok & dwb_we_i & d_tohost;
            wdat_q   <= dwb_dat_i;
            sel_q    <= dwb_sel_i;
         end else if (state == MEM_ST_IDLE && ireq) begin
            i_ok_q <= i_ok;
         end
         if (state == MEM_ST_D_ACK && th_hit_q && !tohost_done_o && th_word != 32'd0) begin
            tohost_done_o <= 1'b1;
            tohost_pass_o <= (th_word == 32'd1);
            tohost_code_o <= th_word[31:1];
         end
      end
   end

   assign iwb_ack_o = (state == MEM_ST_I_ACK);
   assign dwb_ack_o = (state == MEM_ST_D_ACK) &  d_ok_q;
   assign dwb_err_o = (state == MEM_ST_D_ACK) & ~d_ok_q;
   assign iwb_dat_o = (iwb_ack_o && i_ok_q) ? ram_rdata : NOP;
   assign dwb_dat_o = dwb_ack_o ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_wb_unified_mem_slave.sv
// Randomized self-checking bench for wb_unified_mem_slave against a
// word-array reference model of the memory and tohost monitor.
module tb_wb_unified_mem_slave;

   localparam logic [31:0] NOP_W     = 32'h0000_0013;
   localparam int unsigned MEM_BYTES = 8192 * 4;
   localparam int unsigned TH_WORD   = 32'h1000 >> 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] iwb_adr_i, iwb_dat_o;
   logic        iwb_cyc_i, iwb_stb_i, iwb_ack_o;
   logic [31:0] dwb_adr_i, dwb_dat_i, dwb_dat_o;
   logic        dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
   logic [3:0]  dwb_sel_i;
   logic        tohost_done_o, tohost_pass_o;
   logic [30:0] tohost_code_o;

   int n_chk = 0;
   int n_bad = 0;

   logic [31:0] mdl [int unsigned];
   bit          m_done;
   bit          m_pass;
   logic [30:0] m_code;

   always #5 clk = ~clk;

   wb_unified_mem_slave dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .iwb_adr_i     (iwb_adr_i),
      .iwb_cyc_i     (iwb_cyc_i),
      .iwb_stb_i     (iwb_stb_i),
      .iwb_dat_o     (iwb_dat_o),
      .iwb_ack_o     (iwb_ack_o),
      .dwb_adr_i     (dwb_adr_i),
      .dwb_dat_i     (dwb_dat_i),
      .dwb_dat_o     (dwb_dat_o),
      .dwb_we_i      (dwb_we_i),
      .dwb_sel_i     (dwb_sel_i),
      .dwb_cyc_i     (dwb_cyc_i),
      .dwb_stb_i     (dwb_stb_i),
      .dwb_ack_o     (dwb_ack_o),
      .dwb_err_o     (dwb_err_o),
      .tohost_done_o (tohost_done_o),
      .tohost_pass_o (tohost_pass_o),
      .tohost_code_o (tohost_code_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit adr_ok(input logic [31:0] a);
      return a < MEM_BYTES;
   endfunction

   // Model of one store: updates array and tohost monitor from byte-lane rules.
   task automatic model_store(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      int unsigned w;
      logic [31:0] mask, merged;
      bit          known;
      w     = adr >> 2;
      mask  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      known = mdl.exists(w) || (sel == 4'hF);
      merged = mdl.exists(w) ? ((mdl[w] & ~mask) | (dat & mask)) : (dat & mask);
      if (known) mdl[w] = merged;
      if (known && w == TH_WORD && !m_done && merged != 0) begin
         m_done = 1'b1;
         m_pass = (merged == 32'd1);
         m_code = merged[31:1];
      end
   endtask

   task automatic chk_tohost(input string tag);
      chk({tag, ".done"}, {31'd0, tohost_done_o}, {31'd0, m_done});
      chk({tag, ".pass"}, {31'd0, tohost_pass_o}, {31'd0, m_pass});
      chk({tag, ".code"}, {1'b0, tohost_code_o}, {1'b0, m_code});
   endtask

   task automatic chk_data_resp(input string tag, input bit we, input logic [31:0] adr);
      int unsigned w;
      w = adr >> 2;
      if (adr_ok(adr)) begin
         chk({tag, ".ack"}, {31'd0, dwb_ack_o}, 32'd1);
         chk({tag, ".err"}, {31'd0, dwb_err_o}, 32'd0);
         if (mdl.exists(w)) chk({tag, ".dat"}, dwb_dat_o, mdl[w]);
      end else begin
         chk({tag, ".ack"}, {31'd0, dwb_ack_o}, 32'd0);
         chk({tag, ".err"}, {31'd0, dwb_err_o}, 32'd1);
      end
      if (we && adr_ok(adr)) ;
   endtask

   task automatic chk_fetch_resp(input string tag, input logic [31:0] adr);
      int unsigned w;
      w = adr >> 2;
      chk({tag, ".iack"}, {31'd0, iwb_ack_o}, 32'd1);
      if (!adr_ok(adr)) chk({tag, ".idat"}, iwb_dat_o, NOP_W);
      else if (mdl.exists(w)) chk({tag, ".idat"}, iwb_dat_o, mdl[w]);
   endtask

   // All bus tasks start and end at a negedge.
   task automatic dwb_op(input string tag, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
      dwb_adr_i = adr; dwb_dat_i = dat; dwb_we_i = we; dwb_sel_i = sel;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_data_resp(tag, we, adr);
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
      if (we && adr_ok(adr)) model_store(adr, dat, sel);
      @(posedge clk); @(negedge clk);
      chk_tohost(tag);
   endtask

   task automatic iwb_op(input string tag, input logic [31:0] adr);
      iwb_adr_i = adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_fetch_resp(tag, adr);
      iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   // Store and fetch raised together: data wins, fetch acked two cycles later.
   task automatic both_op(input string tag, input logic [31:0] dadr, input logic [31:0] ddat,
                          input logic [3:0] sel, input logic [31:0] iadr);
      dwb_adr_i = dadr; dwb_dat_i = ddat; dwb_we_i = 1'b1; dwb_sel_i = sel;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      iwb_adr_i = iadr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_data_resp(tag, 1'b1, dadr);
      chk({tag, ".iack0"}, {31'd0, iwb_ack_o}, 32'd0);
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
      if (adr_ok(dadr)) model_store(dadr, ddat, sel);
      @(posedge clk); @(negedge clk);
      chk({tag, ".iack1"}, {31'd0, iwb_ack_o}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk_fetch_resp(tag, iadr);
      iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      @(posedge clk); @(negedge clk);
      chk_tohost(tag);
   endtask

   function automatic logic [31:0] rand_adr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0:       a = 32'h0000_8000 + ($urandom_range(0, 255) << 2);
         1:       a = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
         default: a = 32'h0000_0100 + ($urandom_range(0, 31) << 2);
      endcase
      return a | 32'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [31:0] a, d;
      logic [3:0]  s;
      rst_n = 1'b0;
      iwb_adr_i = '0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
      dwb_adr_i = '0; dwb_dat_i = '0; dwb_we_i = 1'b0; dwb_sel_i = '0;
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      m_done = 1'b0; m_pass = 1'b0; m_code = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      chk("rst.iack", {31'd0, iwb_ack_o}, 32'd0);
      chk("rst.idat", iwb_dat_o, NOP_W);
      chk("rst.dack", {31'd0, dwb_ack_o}, 32'd0);
      chk("rst.derr", {31'd0, dwb_err_o}, 32'd0);
      chk("rst.ddat", dwb_dat_o, 32'd0);
      chk_tohost("rst");

      dwb_op("img0", 1'b1, 32'h0, 32'h0000_0297, 4'hF);
      iwb_op("fetch0", 32'h0);

      dwb_op("st200a", 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF);
      dwb_op("st200b", 1'b1, 32'h200, 32'h0000_AA00, 4'b0010);
      dwb_op("ld200", 1'b0, 32'h200, 32'h0, 4'hF);
      chk("ld200.lit", mdl[32'h200 >> 2], 32'hDEAD_AAEF);
      dwb_op("sel0", 1'b1, 32'h200, 32'h1234_5678, 4'b0000);
      dwb_op("ld200b", 1'b0, 32'h200, 32'h0, 4'hF);

      dwb_op("init40", 1'b1, 32'h40, 32'h0, 4'hF);
      both_op("simul", 32'h40, 32'h0010_0093, 4'hF, 32'h40);

      // Strobe held through the ack cycle must not give a second ack there.
      dwb_adr_i = 32'h200; dwb_we_i = 1'b0; dwb_sel_i = 4'hF;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("hold.ack1", {31'd0, dwb_ack_o}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk("hold.ack2", {31'd0, dwb_ack_o}, 32'd0);
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("hold.idle", {31'd0, dwb_ack_o}, 32'd0);

      dwb_op("oor.ld", 1'b0, 32'h0001_0000, 32'h0, 4'hF);
      dwb_op("oor.st", 1'b1, 32'h8000_0200, 32'h5555_5555, 4'hF);
      dwb_op("oor.alias", 1'b0, 32'h200, 32'h0, 4'hF);
      iwb_op("oor.fetch", 32'h0001_0000);

      dwb_op("th0", 1'b1, 32'h1000, 32'h0, 4'hF);
      dwb_op("th7", 1'b1, 32'h1000, 32'h7, 4'hF);
      chk("th7.code3", {1'b0, tohost_code_o}, 32'd3);
      dwb_op("th1late", 1'b1, 32'h1000, 32'h1, 4'hF);

      // Reset landing in the D_ACK cycle of a store.
      dwb_adr_i = 32'h300; dwb_dat_i = 32'h1234_5678; dwb_we_i = 1'b1; dwb_sel_i = 4'hF;
      dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rstmid.ack", {31'd0, dwb_ack_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstmid.drop", {31'd0, dwb_ack_o}, 32'd0);
      dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
      model_store(32'h300, 32'h1234_5678, 4'hF);
      m_done = 1'b0; m_pass = 1'b0; m_code = '0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      chk_tohost("rstmid");
      dwb_op("rstmid.keep", 1'b0, 32'h300, 32'h0, 4'hF);
      dwb_op("th1fresh", 1'b1, 32'h1000, 32'h1, 4'hF);

      for (int i = 0; i < 32; i++)
         dwb_op("rinit", 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF);
      for (int i = 0; i < 150; i++) begin
         a = rand_adr();
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0: dwb_op("rld", 1'b0, a, d, s);
            1: dwb_op("rst", 1'b1, a, d, s);
            2: iwb_op("rfetch", a);
            default: both_op("rboth", a, d, s, ($urandom_range(0, 1) == 1) ? a : rand_adr());
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
